// File: rtl/msrv32_fetch_queue.sv
// Instruction fetch unit: issues one word fetch at a time and buffers returned
// instructions in a 2-entry queue that feeds decode, with redirect on flush.
module msrv32_fetch_queue #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_rvalid_in,
    input  logic [31:0] imem_rdata_in,
    input  logic        flush_in,
    input  logic [31:0] flush_pc_in,
    output logic        valid_out,
    input  logic        ready_in,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DROP
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] req_pc;
    logic [31:0] fifo_pc    [2];
    logic [31:0] fifo_instr [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;
    logic        issue;
    logic        push;
    logic        pop;
    logic [1:0]  flush_pc_unused;

    assign flush_pc_unused = flush_pc_in[1:0];

    // Reset gates the request so nothing is issued while the core is held in reset.
    assign issue         = rst_in & (state == S_IDLE) & ~flush_in & (count < 2'd2);
    assign imem_req_out  = issue;
    assign imem_addr_out = fetch_pc;

    assign push = (state == S_WAIT) & imem_rvalid_in & ~flush_in;
    assign pop  = valid_out & ready_in & ~flush_in;

    assign valid_out = (count != 2'd0);
    assign instr_out = valid_out ? fifo_instr[rd_ptr] : NOP_INSTR;
    assign pc_out    = valid_out ? fifo_pc[rd_ptr]    : 32'h0000_0000;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state    <= S_IDLE;
            fetch_pc <= BOOT_ADDR;
            req_pc   <= BOOT_ADDR;
        end else if (flush_in) begin
            fetch_pc <= {flush_pc_in[31:2], 2'b00};
            // An in-flight response that has not yet arrived must be swallowed.
            case (state)
                S_WAIT, S_DROP: state <= imem_rvalid_in ? S_IDLE : S_DROP;
                default:        state <= S_IDLE;
            endcase
        end else begin
            case (state)
                S_IDLE: begin
                    if (issue) begin
                        req_pc   <= fetch_pc;
                        fetch_pc <= fetch_pc + 32'd4;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid_in) state <= S_IDLE;
                end
                S_DROP: begin
                    if (imem_rvalid_in) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_pc[i]    <= 32'h0000_0000;
                fifo_instr[i] <= NOP_INSTR;
            end
        end else if (flush_in) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) begin
                fifo_pc[wr_ptr]    <= req_pc;
                fifo_instr[wr_ptr] <= imem_rdata_in;
                wr_ptr             <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_msrv32_fetch_queue.sv
// Self-checking bench for msrv32_fetch_queue: a queue-based reference model is
// compared on every falling edge, plus directed scenarios with literal expectations.
module tb_msrv32_fetch_queue;

    localparam logic [31:0] BOOT = 32'h0000_0000;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = 32'h0;
    logic        valid;
    logic        ready = 1'b1;
    logic [31:0] instr;
    logic [31:0] pc;

    int checks = 0;
    int errors = 0;

    // Reference model: pending-fetch flags and a queue of {pc, instr}.
    logic [31:0] m_fetch_pc = BOOT;
    logic [63:0] m_q[$];
    bit          m_busy = 1'b0;
    bit          m_discard = 1'b0;
    logic [31:0] m_req_pc = 32'h0;
    int          m_age = 0;

    // Memory responder settings.
    int mem_lat = 1;
    bit mem_const = 1'b1;

    always #5 clk = ~clk;

    msrv32_fetch_queue #(.BOOT_ADDR(BOOT)) dut (
        .clk_in        (clk),
        .rst_in        (rst_n),
        .imem_req_out  (imem_req),
        .imem_addr_out (imem_addr),
        .imem_rvalid_in(rvalid),
        .imem_rdata_in (rdata),
        .flush_in      (flush),
        .flush_pc_in   (flush_pc),
        .valid_out     (valid),
        .ready_in      (ready),
        .instr_out     (instr),
        .pc_out        (pc)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return mem_const ? 32'h0050_0093 : (a ^ 32'h1234_5013);
    endfunction

    function automatic logic exp_req();
        return rst_n && !m_busy && !flush && (m_q.size() < 2);
    endfunction

    function automatic logic exp_valid();
        return m_q.size() != 0;
    endfunction

    function automatic logic [31:0] exp_instr();
        return (m_q.size() != 0) ? m_q[0][31:0] : NOP;
    endfunction

    function automatic logic [31:0] exp_pc();
        return (m_q.size() != 0) ? m_q[0][63:32] : 32'h0;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin : model_step
        bit issue_now;
        if (!rst_n) begin
            m_fetch_pc = BOOT;
            m_q.delete();
            m_busy     = 1'b0;
            m_discard  = 1'b0;
            m_age      = 0;
        end else begin
            issue_now = exp_req();
            if (flush) begin
                m_q.delete();
                m_fetch_pc = {flush_pc[31:2], 2'b00};
                if (m_busy) begin
                    if (rvalid) begin
                        m_busy    = 1'b0;
                        m_discard = 1'b0;
                    end else begin
                        m_discard = 1'b1;
                    end
                end
            end else begin
                if (m_q.size() != 0 && ready) void'(m_q.pop_front());
                if (m_busy && rvalid) begin
                    if (!m_discard) m_q.push_back({m_req_pc, rdata});
                    m_busy    = 1'b0;
                    m_discard = 1'b0;
                end
            end
            if (issue_now) begin
                m_req_pc   = m_fetch_pc;
                m_fetch_pc = m_fetch_pc + 32'd4;
                m_busy     = 1'b1;
                m_age      = 0;
            end else if (m_busy) begin
                m_age++;
            end
        end
    end

    always @(negedge clk) begin
        check_output("imem_req", {31'b0, imem_req}, {31'b0, exp_req()});
        check_output("imem_addr", imem_addr, m_fetch_pc);
        check_output("valid_out", {31'b0, valid}, {31'b0, exp_valid()});
        check_output("instr_out", instr, exp_instr());
        check_output("pc_out", pc, exp_pc());
    end

    // One clock of stimulus; the memory answers mem_lat cycles after a request.
    task automatic apply_stimulus(input logic rdy, input logic fl, input logic [31:0] fpc);
        @(posedge clk);
        #1;
        ready    = rdy;
        flush    = fl;
        flush_pc = fpc;
        rvalid   = m_busy && (m_age >= mem_lat - 1);
        rdata    = rvalid ? word_at(m_req_pc) : 32'hDEAD_BEEF;
        @(negedge clk);
    endtask

    task automatic wait_req_at(input string name, input logic [31:0] a, input int bound);
        int n = 0;
        while (!(imem_req === 1'b1 && imem_addr === a) && n < bound) begin
            apply_stimulus(1'b1, 1'b0, 32'h0);
            n++;
        end
        check_output(name, imem_addr, a);
    endtask

    task automatic wait_head(input string name, input logic [31:0] p, input int bound);
        int n = 0;
        while (!(valid === 1'b1 && pc === p) && n < bound) begin
            apply_stimulus(1'b1, 1'b0, 32'h0);
            n++;
        end
        check_output(name, pc, p);
    endtask

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        bit stayed_empty;
        int n;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("rst_valid", {31'b0, valid}, 32'd0);
        check_output("rst_instr", instr, NOP);
        check_output("rst_pc", pc, 32'h0);
        check_output("rst_req", {31'b0, imem_req}, 32'd0);

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_output("boot_req", {31'b0, imem_req}, 32'd1);
        check_output("boot_addr", imem_addr, BOOT);

        // Boot with a one-cycle memory and decode always ready.
        mem_const = 1'b1;
        mem_lat   = 1;
        wait_head("boot_head_pc", 32'h0, 10);
        check_output("boot_head_instr", instr, 32'h0050_0093);
        wait_req_at("boot_req_8", 32'h8, 10);

        // Backpressure: two entries fill and fetching stops.
        apply_stimulus(1'b0, 1'b1, 32'h0);
        repeat (8) apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("bp_valid", {31'b0, valid}, 32'd1);
        check_output("bp_head_pc", pc, 32'h0);
        check_output("bp_head_instr", instr, 32'h0050_0093);
        check_output("bp_req", {31'b0, imem_req}, 32'd0);
        apply_stimulus(1'b1, 1'b0, 32'h0);
        check_output("bp_hold_pc", pc, 32'h0);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("bp_second_pc", pc, 32'h4);

        // Flush while waiting: the late response must be dropped.
        mem_const = 1'b0;
        mem_lat   = 3;
        apply_stimulus(1'b1, 1'b1, 32'h8);
        wait_req_at("wait_req_8", 32'h8, 10);
        apply_stimulus(1'b1, 1'b1, 32'h102);
        stayed_empty = 1'b1;
        n = 0;
        while (!(imem_req === 1'b1 && imem_addr === 32'h100) && n < 10) begin
            apply_stimulus(1'b1, 1'b0, 32'h0);
            if (valid !== 1'b0) stayed_empty = 1'b0;
            n++;
        end
        check_output("drop_req_addr", imem_addr, 32'h100);
        check_output("drop_empty", {31'b0, stayed_empty}, 32'd1);
        wait_head("drop_head_pc", 32'h100, 10);
        check_output("drop_head_instr", instr, 32'h1234_5113);

        // Flush in the same cycle as the response.
        mem_lat = 1;
        n = 0;
        while (imem_req !== 1'b1 && n < 10) begin
            apply_stimulus(1'b1, 1'b0, 32'h0);
            n++;
        end
        apply_stimulus(1'b1, 1'b1, 32'h200);
        apply_stimulus(1'b1, 1'b0, 32'h0);
        check_output("coinc_req", {31'b0, imem_req}, 32'd1);
        check_output("coinc_addr", imem_addr, 32'h200);
        check_output("coinc_valid", {31'b0, valid}, 32'd0);
        wait_head("coinc_head_pc", 32'h200, 10);
        check_output("coinc_head_instr", instr, 32'h1234_5213);

        // Address wrap; low target bits are ignored.
        apply_stimulus(1'b1, 1'b1, 32'hFFFF_FFFE);
        wait_req_at("wrap_req_top", 32'hFFFF_FFFC, 10);
        wait_head("wrap_head_top", 32'hFFFF_FFFC, 10);
        check_output("wrap_instr_top", instr, 32'hEDCB_AFEF);
        wait_req_at("wrap_req_zero", 32'h0, 10);
        wait_head("wrap_head_zero", 32'h0, 10);
        check_output("wrap_instr_zero", instr, 32'h1234_5013);

        // Asynchronous reset between edges with a full queue.
        repeat (8) apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("pre_rst_valid", {31'b0, valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_valid", {31'b0, valid}, 32'd0);
        check_output("async_instr", instr, NOP);
        check_output("async_pc", pc, 32'h0);
        check_output("async_req", {31'b0, imem_req}, 32'd0);
        rvalid = 1'b0;
        flush  = 1'b0;
        ready  = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_output("rerun_req", {31'b0, imem_req}, 32'd1);
        check_output("rerun_addr", imem_addr, BOOT);
        wait_head("rerun_head_pc", BOOT, 10);
        check_output("rerun_head_instr", instr, 32'h1234_5013);
        repeat (3) apply_stimulus(1'b1, 1'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/msrv32_fetch_queue.md
MSRV32_FETCH_QUEUE -- requirements
Module: msrv32_fetch_queue

Interface
REQ-001 SHALL have parameter BOOT_ADDR, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk_in  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_in  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port imem_req_out  output  1  fetch request to instruction memory.
REQ-005 SHALL have port imem_addr_out  output  32  fetch address, word aligned.
REQ-006 SHALL have port imem_rvalid_in  input  1  read data valid, one or more cycles after the request.
REQ-007 SHALL have port imem_rdata_in  input  32  instruction word returned by memory.
REQ-008 SHALL have port flush_in  input  1  branch/jump redirect from execute.
REQ-009 SHALL have port flush_pc_in  input  32  redirect target.
REQ-010 SHALL have port valid_out  output  1  queue head holds a valid instruction.
REQ-011 SHALL have port ready_in  input  1  decode/immediate-generation stage accepts the head.
REQ-012 SHALL have port instr_out  output  32  head instruction; bits [31:7] feed the immediate generator.
REQ-013 SHALL have port pc_out  output  32  PC of the head instruction.

Function
REQ-014 SHALL hold fetch_pc, a 2-entry FIFO of {pc, instr}, a count of 0..2, and a 3-state FSM: S_IDLE (no request outstanding), S_WAIT (one request outstanding, response kept), S_DROP (one request outstanding, response discarded).
REQ-015 SHALL drive imem_req_out = (state==S_IDLE) & ~flush_in & (count<2), and imem_addr_out = fetch_pc; it is combinational.
REQ-016 SHALL, on a request, latch req_pc = fetch_pc, advance fetch_pc by 4 modulo 2^32 (32'hFFFF_FFFC wraps to 0), and go S_IDLE->S_WAIT.
REQ-017 SHALL, in S_WAIT with imem_rvalid_in=1 and flush_in=0, push {req_pc, imem_rdata_in} and go to S_IDLE; a new request is possible the next cycle, never in the same cycle.
REQ-018 SHALL ignore imem_rvalid_in in S_IDLE; no push and no state change.
REQ-019 SHALL pop the head when valid_out & ready_in; push and pop in the same cycle leave count unchanged.
REQ-020 SHALL drive valid_out = (count!=0); instr_out/pc_out show the head entry, or 32'h0000_0013 (NOP) and 32'h0 when empty.
REQ-021 SHALL, on flush_in=1, clear the FIFO (count=0), set fetch_pc = {flush_pc_in[31:2],2'b00}, suppress any pop and any push that cycle, and go to the next state as follows:
  - S_IDLE -> S_IDLE.
  - S_WAIT -> S_DROP if imem_rvalid_in=0, else S_IDLE.
  - S_DROP -> S_DROP if imem_rvalid_in=0, else S_IDLE.
REQ-022 SHALL, in S_DROP with imem_rvalid_in=1 and no flush, discard the data and go to S_IDLE; no request is issued while in S_DROP.
REQ-023 SHALL never overflow: a request is issued only when count<2 and nothing is outstanding, so a push always finds room.
REQ-024 SHALL keep valid_out, instr_out and pc_out stable while valid_out=1 & ready_in=0 and no flush occurs.

Reset
REQ-025 SHALL, while rst_in=0 and regardless of clock, set fetch_pc=BOOT_ADDR, count=0, state=S_IDLE, valid_out=0, instr_out=32'h0000_0013, pc_out=0; imem_req_out is 0 during reset.
REQ-026 SHALL, when reset is asserted mid-operation, abandon any outstanding request; a response arriving after release is ignored per REQ-018 unless a new request is outstanding.
REQ-027 SHALL issue the first request (imem_addr_out=BOOT_ADDR) in the first cycle after rst_in rises.

Verification
REQ-028 SHALL cover boot: release reset, memory returns 32'h00500093 one cycle after each request, ready_in=1 -> addresses 0,4,8...; valid_out rises with instr_out=32'h00500093, pc_out=0.
REQ-029 SHALL cover backpressure: ready_in=0 with 1-cycle memory -> two entries (pc 0,4) fill; imem_req_out stays 0; head holds pc 0 until ready_in=1.
REQ-030 SHALL cover flush in S_WAIT: request at pc 8, flush_in=1 with flush_pc_in=32'h0000_0102 before rvalid -> late response dropped; next request at 32'h0000_0100; valid_out=0 until it returns.
REQ-031 SHALL cover flush coincident with rvalid: the response is not pushed and the next request goes to the flush target the following cycle.
REQ-032 SHALL cover wrap: flush to 32'hFFFF_FFFC -> requests at FFFF_FFFC then 0000_0000, with pc_out matching each.
REQ-033 SHALL cover async reset mid-fetch: rst_in=0 between clock edges with count=2 -> valid_out=0 immediately; after release the first request is at BOOT_ADDR.
